axi4_rd_arbiter: RTL
====================

// Module: axi4_rd_arbiter
// PURPOSE
//  Shares one downstream AXI4 read port (AR/R) between two upstream read masters (m0, m1), e.g. IFU and LSU,
//  ahead of the SoC read path (delay models, xbar). One burst in flight; grant held from AR issue to final R beat.
//  Round-robin or fixed-priority arbitration; AR fields registered, R channel routed combinationally to owner.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  read data width
//  ID_W    4   AXI ID width, passed through unchanged
//  RR      1   1: round-robin after each completed burst; 0: fixed priority, m0 wins
// PORTS
//  clock                  in   1       system clock
//  reset                  in   1       asynchronous, active-low reset
//  mX_arvalid/arready     in/out 1     X=0,1 upstream AR handshake
//  mX_arid/araddr         in   ID_W/ADDR_W   upstream AR id, address
//  mX_arlen/arsize/arburst in  8/3/2   upstream AR burst attributes
//  mX_rvalid/rready       out/in 1     upstream R handshake
//  mX_rid/rdata/rresp/rlast out ID_W/DATA_W/2/1  upstream R payload
//  out_arvalid/arready    out/in 1     downstream AR handshake
//  out_arid/araddr/arlen/arsize/arburst out  ID_W/ADDR_W/8/3/2  downstream AR payload (registered)
//  out_rvalid/rready      in/out 1     downstream R handshake
//  out_rid/rdata/rresp/rlast in ID_W/DATA_W/2/1  downstream R payload
// BEHAVIOUR
//  Reset (reset==0): state=IDLE, prio=m0, out_arvalid=0, out_rready=0, mX_arready=0, mX_rvalid=0, counters=0.
//  FSM IDLE -> AR -> R -> IDLE.
//  IDLE: pick winner among mX_arvalid (RR: prio master first; RR=0: m0 first). Winner's arready=1 for exactly
//   that cycle (loser arready=0); on handshake latch AR fields + owner, go AR. No request: stay IDLE.
//  AR: out_arvalid=1 with latched fields, held stable until out_arready; then go R. Latency upstream AR
//   handshake -> out_arvalid = 1 cycle. mX_arready=0 in AR and R.
//  R: owner's rvalid/rid/rdata/rresp/rlast = out_* (combinational); out_rready = owner's rready;
//   non-owner rvalid=0, its R payload driven 0. On out_rvalid&&out_rready&&out_rlast: go IDLE;
//   RR=1 -> prio = other master than owner. Non-last beats keep state.
//  arlen=0 (single beat): R state lasts until that single rlast beat; zero-beat path does not exist.
//  Simultaneous requests in IDLE: only winner accepted; loser keeps arvalid, wins next IDLE under RR.
//  New upstream request during AR/R: not accepted; earliest accept is the cycle after return to IDLE.
//  Reset mid-burst: immediate return to IDLE, outstanding downstream beats not tracked (system reset only).
//  out_rvalid in IDLE/AR: ignored, out_rready=0.
// CONFIGURATION
//  AXI4_RD_ARB_PERF_EN defined: extra outputs perf_grant0, perf_grant1 (32b, count accepted ARs per master)
//   and perf_wait (32b, cycles in which a master has arvalid=1 but is not accepted); wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  Shared package axi4_pkg: AXI4 burst/resp constants (BURST_INCR, RESP_OKAY/SLVERR), FSM state enum
//   (ARB_IDLE, ARB_AR, ARB_R) width 2.
//  Sub-module axi4_rr_pick: 2-way winner select (req[1:0], prio, rr) -> grant one-hot; combinational, reusable
//   for the planned write-side arbiter.
// TESTING
//  m0 single read addr 0x8000_0000 arlen=0, m1 idle -> out_araddr=0x8000_0000 one cycle after accept, rdata
//   0x1234_5678 routed to m0 only, m1_rvalid stays 0, FSM back to IDLE after rlast.
//  m0,m1 both assert arvalid same cycle after reset, RR=1 -> m0 granted first, m1 granted in first IDLE
//   after m0 rlast; third back-to-back m0 request waits behind m1.
//  RR=0, both requesting continuously -> m1 never granted while m0 holds arvalid; RR=1 -> strict alternation.
//  m1 burst arlen=3 with owner rready toggling 1,0,1,0 -> 4 beats forwarded in order, out_rready mirrors
//   m1_rready, no beat lost or duplicated, rlast only on beat 4.
//  out_arready held 0 for 5 cycles -> out_arvalid and all AR fields stable all 5 cycles; upstream arready=0.
//  reset pulled low mid-burst (beat 2 of 4) -> next cycle all valids 0, state IDLE; PERF_EN build: perf
//   counters read 0, and after 3 m0 grants perf_grant0=3.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and the read-arbiter state encoding.
// Revision 1.0
`default_nettype none

package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi4_rr_pick.sv
// axi4_rr_pick: two-way combinational winner select, one-hot grant.
// Revision 1.0
`default_nettype none

module axi4_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       rr,
    output logic [1:0] grant
);

    // prio names the favoured master when both request; it only matters in round-robin mode.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (rr && prio) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: shares one AXI4 read port between two masters, one burst in flight.
// Optional AXI4_RD_ARB_PERF_EN adds grant/wait performance counters. Revision 1.0
`default_nettype none

module axi4_rd_arbiter
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int RR     = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,

    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,

    output logic              out_arvalid,
    input  logic              out_arready,
    output logic [ID_W-1:0]   out_arid,
    output logic [ADDR_W-1:0] out_araddr,
    output logic [7:0]        out_arlen,
    output logic [2:0]        out_arsize,
    output logic [1:0]        out_arburst,
    input  logic              out_rvalid,
    output logic              out_rready,
    input  logic [ID_W-1:0]   out_rid,
    input  logic [DATA_W-1:0] out_rdata,
    input  logic [1:0]        out_rresp,
    input  logic              out_rlast
`ifdef AXI4_RD_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_wait
`endif
);

    localparam logic RR_EN = (RR != 0);

    arb_state_e state;
    logic       prio;
    logic       owner;
    logic [1:0] req;
    logic [1:0] grant;
    logic       idle;
    logic       in_r;
    logic       take0;
    logic       take1;
    logic       burst_done;

    assign req = {m1_arvalid, m0_arvalid};

    axi4_rr_pick u_pick (
        .req   (req),
        .prio  (prio),
        .rr    (RR_EN),
        .grant (grant)
    );

    assign idle       = (state == ARB_IDLE);
    assign in_r       = (state == ARB_R);
    assign m0_arready = idle & grant[0];
    assign m1_arready = idle & grant[1];
    assign take0      = m0_arvalid & m0_arready;
    assign take1      = m1_arvalid & m1_arready;

    // R channel is a pure mux onto the owner; the other master sees an all-zero channel.
    assign out_rready = in_r & (owner ? m1_rready : m0_rready);
    assign burst_done = out_rvalid & out_rready & out_rlast;
    assign m0_rvalid  = in_r & ~owner & out_rvalid;
    assign m1_rvalid  = in_r &  owner & out_rvalid;
    assign {m0_rid, m0_rdata, m0_rresp, m0_rlast} =
        (in_r & ~owner) ? {out_rid, out_rdata, out_rresp, out_rlast} : '0;
    assign {m1_rid, m1_rdata, m1_rresp, m1_rlast} =
        (in_r &  owner) ? {out_rid, out_rdata, out_rresp, out_rlast} : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ARB_IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            out_arvalid <= 1'b0;
            out_arid    <= '0;
            out_araddr  <= '0;
            out_arlen   <= '0;
            out_arsize  <= '0;
            out_arburst <= BURST_INCR;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (take0 | take1) begin
                        state       <= ARB_AR;
                        owner       <= take1;
                        out_arvalid <= 1'b1;
                        if (take1) begin
                            out_arid    <= m1_arid;
                            out_araddr  <= m1_araddr;
                            out_arlen   <= m1_arlen;
                            out_arsize  <= m1_arsize;
                            out_arburst <= m1_arburst;
                        end else begin
                            out_arid    <= m0_arid;
                            out_araddr  <= m0_araddr;
                            out_arlen   <= m0_arlen;
                            out_arsize  <= m0_arsize;
                            out_arburst <= m0_arburst;
                        end
                    end
                end
                ARB_AR: begin
                    if (out_arready) begin
                        out_arvalid <= 1'b0;
                        state       <= ARB_R;
                    end
                end
                ARB_R: begin
                    if (burst_done) begin
                        state <= ARB_IDLE;
                        if (RR_EN) begin
                            prio <= ~owner;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef AXI4_RD_ARB_PERF_EN
    logic waiting;
    assign waiting = (m0_arvalid & ~m0_arready) | (m1_arvalid & ~m1_arready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_wait   <= '0;
        end else begin
            if (take0) perf_grant0 <= perf_grant0 + 32'd1;
            if (take1) perf_grant1 <= perf_grant1 + 32'd1;
            if (waiting) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
